uart_rx_ctrl: RTL

//  Frame-sequencing controller for the UART receiver. Tracks oversampling edges and frame bits,
//  and enables the sampler, deserializer and start/parity/stop checkers at the right bit.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_ctrl_if.sv | 36 +++
 rtl/uart_rx_edge_bit_cnt.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 80 ++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: frame-sequencer state codes
// and the oversampling ratios the receiver supports.
package uart_rx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX frame controller (slave) and the line plus
// datapath checkers around it (master).
interface uart_rx_ctrl_if #(parameter int CNT_W = 6);

  logic             RX_IN;
  logic             PAR_EN;
  logic [CNT_W-1:0] Prescale;
  logic             strt_glitch;
  logic             par_err;
  logic             stp_err;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             dat_samp_en;
  logic             deser_en;
  logic             strt_chk_en;
  logic             par_chk_en;
  logic             stp_chk_en;
  logic             data_valid;
  logic             frame_err;
  logic [2:0]       state_dbg;

  // data_valid / frame_err are valid-only one-cycle strobes: there is no ready,
  // the consumer must take the frame in the cycle the strobe is high.
  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, state_dbg
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, state_dbg
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter; edge_cnt wraps at
// presc-1 and advances bit_cnt. Clear has priority over counting.
module uart_rx_edge_bit_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] presc,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (edge_cnt == presc - CNT_W'(1)) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks START/DATA/PARITY/STOP on oversampling
// edges, strobes the datapath checkers and qualifies the received frame.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 6
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_ctrl_if.slave bus
);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] presc_q, presc_in, chk;
  logic [CNT_W-1:0] edge_cnt, bit_cnt;
  logic             par_en_q, end_bit, stop_done, leave_idle;

  always_comb begin
    presc_in = CNT_W'(PRESC_8);
    if (bus.Prescale == CNT_W'(PRESC_16) || bus.Prescale == CNT_W'(PRESC_32))
      presc_in = bus.Prescale;
  end

  assign chk        = (presc_q >> 1) + CNT_W'(2);
  assign end_bit    = (edge_cnt == presc_q - CNT_W'(1));
  assign stop_done  = (state == STOP) && (edge_cnt == chk + CNT_W'(1));
  assign leave_idle = (state == IDLE) && !bus.RX_IN;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.RX_IN) state_nxt = START;
      START:   if (end_bit) state_nxt = bus.strt_glitch ? IDLE : DATA;
      DATA:    if (end_bit && bit_cnt == CNT_W'(DATA_WIDTH))
                 state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (end_bit) state_nxt = STOP;
      STOP:    if (stop_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ratio and parity mode are frozen for the frame at the start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      presc_q  <= CNT_W'(PRESC_8);
      par_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (leave_idle) begin
        presc_q  <= presc_in;
        par_en_q <= bus.PAR_EN;
      end
    end
  end

  uart_rx_edge_bit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state != IDLE),
    .clr      ((state == IDLE) || (state_nxt == IDLE)),
    .presc    (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.dat_samp_en = (state != IDLE);
  assign bus.deser_en    = (state == DATA) && (edge_cnt == chk);
  assign bus.strt_chk_en = (state == START);
  assign bus.par_chk_en  = (state == PARITY);
  assign bus.stp_chk_en  = (state == STOP);
  // Gated by RST so a reset landing on the qualifying edge emits nothing.
  assign bus.data_valid  = stop_done && !RST && !bus.par_err && !bus.stp_err;
  assign bus.frame_err   = stop_done && !RST && (bus.par_err || bus.stp_err);
  assign bus.state_dbg   = state;

endmodule
